// File: rtl/instruction_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage_if
//   Bundles every non-clock/reset signal of the instruction fetch stage.
//   master : seen by the fetch stage (drives the PC, IF/ID and status outputs)
//   slave  : seen by the surroundings (hazard unit, branch resolve, imem, bench)
//
//   Hazard/redirect inputs : pc_write, IF_ID_write, flush, branch_target
//   Instruction memory     : imem_addr (out), imem_rdata (in, same cycle)
//   Pipeline outputs       : pc_out, IF_ID_pc_out, instr_IF_ID, if_id_valid
//   Status                 : halted, fetch_count, state_dbg (0 RUN, 1 DRAIN,
//                            2 HALTED)
//
//   Handshake: there is no valid/ready pair. pc_write and IF_ID_write are
//   level enables sampled at every rising clk edge; 0 means hold that
//   register this cycle. flush is a one-cycle redirect request that
//   outranks both enables. imem_rdata must be valid for imem_addr within
//   the same cycle.
// ---------------------------------------------------------------------------
interface instruction_fetch_stage_if;
  logic        pc_write;
  logic        IF_ID_write;
  logic        flush;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] IF_ID_pc_out;
  logic [31:0] instr_IF_ID;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic [1:0]  state_dbg;

  modport master (
    input  pc_write, IF_ID_write, flush, branch_target, imem_rdata,
    output imem_addr, pc_out, IF_ID_pc_out, instr_IF_ID, if_id_valid,
           halted, fetch_count, state_dbg
  );

  modport slave (
    output pc_write, IF_ID_write, flush, branch_target, imem_rdata,
    input  imem_addr, pc_out, IF_ID_pc_out, instr_IF_ID, if_id_valid,
           halted, fetch_count, state_dbg
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// ---------------------------------------------------------------------------
// instruction_fetch_stage
//   PC register, IF/ID pipeline register and a halt detector for a simple
//   in-order pipeline. An all-zero instruction word marks end of program:
//   fetch stops advancing, DRAIN_CYCLES further advancing cycles let the
//   older instructions leave the pipe, then the stage halts until reset.
//   A taken branch (flush) during DRAIN means the zero word was on the
//   wrong path, so the drain is cancelled.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : synchronous, active-high
//     bus    : instruction_fetch_stage_if.master (see interface header)
//
//   Parameters
//     RESET_PC     : PC loaded on reset
//     DRAIN_CYCLES : advancing drain cycles after the zero fetch before halt
// ---------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  instruction_fetch_stage_if.master  bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [31:0] drain_cnt_q, drain_cnt_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        halted_q, halted_d;
  logic [31:0] redirect_pc;
  logic        zero_word;

  assign redirect_pc = {bus.branch_target[31:2], 2'b00};
  assign zero_word   = (bus.imem_rdata == 32'h0);

  // Next-state / next-value logic. Defaults hold every register.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ifid_pc_d   = ifid_pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    drain_cnt_d = drain_cnt_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      RUN: begin
        if (bus.flush) begin
          // Redirect beats stall and beats a zero word fetched this cycle.
          pc_d    = redirect_pc;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (!zero_word) begin
          if (bus.pc_write) begin
            pc_d = pc_q + 32'd4;  // wraps naturally at 2^32
          end
          if (bus.IF_ID_write) begin
            ifid_pc_d = pc_q;
            instr_d   = bus.imem_rdata;
            valid_d   = 1'b1;
            if (fetch_cnt_q != 32'hFFFF_FFFF) begin
              fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
          end
        end else if (bus.pc_write) begin
          // End-of-program marker: PC freezes on the zero word.
          state_d     = DRAIN;
          drain_cnt_d = 32'd0;
          if (bus.IF_ID_write) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
      end

      DRAIN: begin
        if (bus.flush) begin
          state_d     = RUN;
          pc_d        = redirect_pc;
          instr_d     = NOP_INSTR;
          valid_d     = 1'b0;
          drain_cnt_d = 32'd0;
        end else begin
          if (bus.IF_ID_write) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
          // Only advancing cycles move the drain along.
          if (bus.pc_write) begin
            drain_cnt_d = drain_cnt_q + 32'd1;
            if (drain_cnt_d >= 32'(DRAIN_CYCLES)) begin
              state_d = HALTED;
            end
          end
        end
      end

      HALTED: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end

      default: begin
        state_d = RUN;
      end
    endcase

    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      ifid_pc_q   <= 32'h0;
      instr_q     <= NOP_INSTR;
      valid_q     <= 1'b0;
      drain_cnt_q <= 32'h0;
      fetch_cnt_q <= 32'h0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ifid_pc_q   <= ifid_pc_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      drain_cnt_q <= drain_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      halted_q    <= halted_d;
    end
  end

  assign bus.imem_addr    = pc_q;
  assign bus.pc_out       = pc_q;
  assign bus.IF_ID_pc_out = ifid_pc_q;
  assign bus.instr_IF_ID  = instr_q;
  assign bus.if_id_valid  = valid_q;
  assign bus.halted       = halted_q;
  assign bus.fetch_count  = fetch_cnt_q;
  assign bus.state_dbg    = state_q;

endmodule
